vga_output_timing_generator: RTL and testbench

// Transmit side of the VGA interface: regenerates HSYNC/VSYNC/DATA_ENABLE timing and streams processed

---
 rtl/vga_output_timing_generator.sv | 170 +++++++++++++++++
 tb/tb_vga_output_timing_generator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_output_timing_generator.sv
// VGA transmit timing generator.
// Walks the (h,v) raster one position per I_ENABLE tick, issues one frame-buffer
// read per active pixel, and delays HSYNC/VSYNC/DE by two ticks so they line up
// with the grayscale data that returns one clock after each read.
module vga_output_timing_generator #(
  parameter int   P_PIXEL_DEPTH    = 24,
  parameter int   P_HACT           = 640,
  parameter int   P_HFP            = 16,
  parameter int   P_HSW            = 96,
  parameter int   P_HBP            = 48,
  parameter int   P_VACT           = 480,
  parameter int   P_VFP            = 10,
  parameter int   P_VSH            = 2,
  parameter int   P_VBP            = 33,
  parameter logic P_HSYNC_POL      = 1'b0,
  parameter logic P_VSYNC_POL      = 1'b0,
  localparam int  P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
  localparam int  P_COLUMN_BITS    = $clog2(P_HACT),
  localparam int  P_ROW_BITS       = $clog2(P_VACT)
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic                        I_ENABLE,
  input  logic                        I_FRAME_VALID,
  input  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
  output logic [P_COLUMN_BITS-1:0]    O_READ_COLUMN,
  output logic [P_ROW_BITS-1:0]       O_READ_ROW,
  output logic                        O_READ_ENABLE,
  output logic [P_PIXEL_DEPTH-1:0]    O_PIXEL,
  output logic                        O_HSYNC,
  output logic                        O_VSYNC,
  output logic                        O_DATA_ENABLE,
  output logic                        O_FRAME_START
);

  localparam int HTOTAL = P_HACT + P_HFP + P_HSW + P_HBP;
  localparam int VTOTAL = P_VACT + P_VFP + P_VSH + P_VBP;
  // One spare bit of headroom so every boundary constant (including sync end
  // when the back porch is zero) fits in the counter width.
  localparam int HBITS  = $clog2(HTOTAL + 1);
  localparam int VBITS  = $clog2(VTOTAL + 1);

  localparam logic [HBITS-1:0] H_LAST     = HBITS'(HTOTAL - 1);
  localparam logic [HBITS-1:0] H_ACT      = HBITS'(P_HACT);
  localparam logic [HBITS-1:0] H_SYNC_BEG = HBITS'(P_HACT + P_HFP);
  localparam logic [HBITS-1:0] H_SYNC_END = HBITS'(P_HACT + P_HFP + P_HSW);
  localparam logic [VBITS-1:0] V_LAST     = VBITS'(VTOTAL - 1);
  localparam logic [VBITS-1:0] V_ACT      = VBITS'(P_VACT);
  localparam logic [VBITS-1:0] V_SYNC_BEG = VBITS'(P_VACT + P_VFP);
  localparam logic [VBITS-1:0] V_SYNC_END = VBITS'(P_VACT + P_VFP + P_VSH);

  // Line-level timing for one raster position; pix_ok marks a pixel whose read
  // was actually issued (active area inside a valid frame).
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic pix_ok;
  } timing_t;

  localparam timing_t IDLE = timing_t'({~P_HSYNC_POL, ~P_VSYNC_POL, 2'b00});

  logic [HBITS-1:0]         r_h;
  logic [VBITS-1:0]         r_v;
  logic                     r_frame;
  logic                     r_frame_start;
  timing_t                  r_dly;
  logic                     r_hsync;
  logic                     r_vsync;
  logic                     r_de;
  logic [P_PIXEL_DEPTH-1:0] r_pixel;

  logic    w_h_act;
  logic    w_v_act;
  logic    w_active;
  logic    w_hs_on;
  logic    w_vs_on;
  logic    w_h_last;
  logic    w_v_last;
  logic    w_wrap;
  timing_t w_cur;

  assign w_h_act  = (r_h < H_ACT);
  assign w_v_act  = (r_v < V_ACT);
  assign w_active = w_h_act & w_v_act;
  assign w_hs_on  = (r_h >= H_SYNC_BEG) & (r_h < H_SYNC_END);
  assign w_vs_on  = (r_v >= V_SYNC_BEG) & (r_v < V_SYNC_END);
  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  // Current tick moves the raster from the last position back to (0,0).
  assign w_wrap   = w_h_last & w_v_last;

  // Timing of the current raster position, polarised for the display.
  always_comb begin
    w_cur        = IDLE;
    w_cur.hsync  = w_hs_on ? P_HSYNC_POL : ~P_HSYNC_POL;
    w_cur.vsync  = w_vs_on ? P_VSYNC_POL : ~P_VSYNC_POL;
    w_cur.de     = w_active;
    w_cur.pix_ok = w_active & r_frame;
  end

  // Frame-buffer read port: address follows the raster, zero outside active video.
  always_comb begin
    O_READ_COLUMN = '0;
    O_READ_ROW    = '0;
    if (w_active) begin
      O_READ_COLUMN = r_h[P_COLUMN_BITS-1:0];
      O_READ_ROW    = r_v[P_ROW_BITS-1:0];
    end
    O_READ_ENABLE = I_ENABLE & w_cur.pix_ok;
  end

  // Raster counters; reset parks them on the last position so the first tick lands on (0,0).
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_h <= H_LAST;
      r_v <= V_LAST;
    end else if (I_ENABLE) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + VBITS'(1);
      end else begin
        r_h <= r_h + HBITS'(1);
      end
    end
  end

  // Frame-valid is sampled only when entering (0,0) so a frame is either fully read or fully blank.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_frame <= 1'b0;
    end else if (I_ENABLE && w_wrap) begin
      r_frame <= I_FRAME_VALID;
    end
  end

  // Single-clock frame-start strobe following the wrapping tick.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= I_ENABLE & w_wrap;
    end
  end

  // Two-tick timing pipe: stage one waits for the read data, stage two drives the pins.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_dly   <= IDLE;
      r_hsync <= ~P_HSYNC_POL;
      r_vsync <= ~P_VSYNC_POL;
      r_de    <= 1'b0;
      r_pixel <= '0;
    end else if (I_ENABLE) begin
      r_dly   <= w_cur;
      r_hsync <= r_dly.hsync;
      r_vsync <= r_dly.vsync;
      r_de    <= r_dly.de;
      // Blank frames still carry DE but send black.
      r_pixel <= r_dly.pix_ok ? {3{I_PIXEL}} : '0;
    end
  end

  assign O_HSYNC       = r_hsync;
  assign O_VSYNC       = r_vsync;
  assign O_DATA_ENABLE = r_de;
  assign O_PIXEL       = r_pixel;
  assign O_FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_output_timing_generator.sv
// Bench for vga_output_timing_generator on a tiny 8x6 raster.
// Stimulus pushes per-tick expectations from a raster-position model into
// queues; a negedge monitor pops and compares against both polarity variants.
module tb_vga_output_timing_generator;

  localparam int HACT = 4, HFP = 1, HSW = 2, HBP = 1;
  localparam int VACT = 3, VFP = 1, VSH = 1, VBP = 1;
  localparam int HT = HACT + HFP + HSW + HBP;
  localparam int VT = VACT + VFP + VSH + VBP;
  localparam int FT = HT * VT;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_ENABLE;
  logic        I_FRAME_VALID;
  logic [7:0]  I_PIXEL;

  logic [1:0]  O_READ_COLUMN, O_READ_ROW;
  logic        O_READ_ENABLE, O_HSYNC, O_VSYNC, O_DATA_ENABLE, O_FRAME_START;
  logic [23:0] O_PIXEL;

  logic [1:0]  d2_col, d2_row;
  logic        d2_re, d2_hs, d2_vs, d2_de, d2_fs;
  logic [23:0] d2_pix;

  vga_output_timing_generator #(
    .P_PIXEL_DEPTH(24), .P_HACT(HACT), .P_HFP(HFP), .P_HSW(HSW), .P_HBP(HBP),
    .P_VACT(VACT), .P_VFP(VFP), .P_VSH(VSH), .P_VBP(VBP),
    .P_HSYNC_POL(1'b0), .P_VSYNC_POL(1'b0)
  ) u_dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE), .I_FRAME_VALID(I_FRAME_VALID),
    .I_PIXEL(I_PIXEL), .O_READ_COLUMN(O_READ_COLUMN), .O_READ_ROW(O_READ_ROW),
    .O_READ_ENABLE(O_READ_ENABLE), .O_PIXEL(O_PIXEL), .O_HSYNC(O_HSYNC), .O_VSYNC(O_VSYNC),
    .O_DATA_ENABLE(O_DATA_ENABLE), .O_FRAME_START(O_FRAME_START)
  );

  vga_output_timing_generator #(
    .P_PIXEL_DEPTH(24), .P_HACT(HACT), .P_HFP(HFP), .P_HSW(HSW), .P_HBP(HBP),
    .P_VACT(VACT), .P_VFP(VFP), .P_VSH(VSH), .P_VBP(VBP),
    .P_HSYNC_POL(1'b1), .P_VSYNC_POL(1'b1)
  ) u_dut_pos (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE), .I_FRAME_VALID(I_FRAME_VALID),
    .I_PIXEL(I_PIXEL), .O_READ_COLUMN(d2_col), .O_READ_ROW(d2_row),
    .O_READ_ENABLE(d2_re), .O_PIXEL(d2_pix), .O_HSYNC(d2_hs), .O_VSYNC(d2_vs),
    .O_DATA_ENABLE(d2_de), .O_FRAME_START(d2_fs)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct packed { logic hs; logic vs; logic de; logic [23:0] pix; } out_t;
  typedef struct packed { logic re; logic [1:0] col; logic [1:0] row; logic wrap; } rd_t;

  out_t outq[$];
  rd_t  rdq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state: next raster position and frame flag
  int         m_p;
  logic       m_flag;
  logic [7:0] salt;

  function automatic logic [7:0] gray(input int c, input int r);
    return 8'(c + 16 * r) ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // frame-buffer model: data for the address read this cycle appears just after the edge
  logic [7:0] fb_next;
  logic       fb_go = 1'b0;
  always @(negedge I_CLK) begin
    if (O_READ_ENABLE === 1'b1) begin
      fb_next = gray(int'(O_READ_COLUMN), int'(O_READ_ROW));
      fb_go   = 1'b1;
    end
  end
  always @(posedge I_CLK) begin
    if (fb_go) begin
      fb_go = 1'b0;
      #1 I_PIXEL = fb_next;
    end
  end

  // one enabled tick, followed by gap idle cycles
  task automatic tick(input logic fv, input int gap);
    out_t o;
    rd_t  r;
    int   h, v;
    logic act;
    h     = m_p % HT;
    v     = m_p / HT;
    act   = (h < HACT) && (v < VACT);
    o.hs  = (h >= HACT + HFP) && (h < HACT + HFP + HSW);
    o.vs  = (v >= VACT + VFP) && (v < VACT + VFP + VSH);
    o.de  = act;
    o.pix = (act && m_flag) ? {3{gray(h, v)}} : 24'h0;
    r.re  = act && m_flag;
    r.col = act ? 2'(h) : 2'd0;
    r.row = act ? 2'(v) : 2'd0;
    r.wrap = (m_p == FT - 1);
    rdq.push_back(r);
    outq.push_back(o);
    if (r.wrap) m_flag = fv;
    m_p = (m_p + 1) % FT;
    I_FRAME_VALID = fv;
    I_ENABLE      = 1'b1;
    @(posedge I_CLK); #2;
    I_ENABLE      = 1'b0;
    I_FRAME_VALID = 1'($urandom);
    repeat (gap) begin @(posedge I_CLK); #2; end
  endtask

  task automatic restart_model();
    outq.delete();
    rdq.delete();
    outq.push_back('0);
    m_p    = FT - 1;
    m_flag = 1'b0;
  endtask

  // monitor
  logic tick_seen = 1'b0;
  always @(posedge I_CLK) tick_seen = (I_ENABLE === 1'b1) && (I_RESET === 1'b1);

  out_t exp_o = '0;
  logic exp_fs = 1'b0;
  logic pend_wrap = 1'b0;
  rd_t  rr;
  always @(negedge I_CLK) begin
    if (I_RESET !== 1'b1) begin
      exp_o     = '0;
      exp_fs    = 1'b0;
      pend_wrap = 1'b0;
      chk("rst_hsync", O_HSYNC, 1'b1);
      chk("rst_vsync", O_VSYNC, 1'b1);
      chk("rst_de", O_DATA_ENABLE, 1'b0);
      chk("rst_pixel", O_PIXEL, 24'h0);
      chk("rst_re", O_READ_ENABLE, 1'b0);
      chk("rst_fs", O_FRAME_START, 1'b0);
      chk("rst_hsync_pos", d2_hs, 1'b0);
      chk("rst_vsync_pos", d2_vs, 1'b0);
    end else begin
      exp_fs = 1'b0;
      if (tick_seen) begin
        if (outq.size() == 0) begin
          n_chk++;
          $display("FAIL outq_underflow at %0t", $time);
        end else begin
          exp_o = outq.pop_front();
        end
        exp_fs = pend_wrap;
      end
      chk("hsync", O_HSYNC, !exp_o.hs);
      chk("vsync", O_VSYNC, !exp_o.vs);
      chk("de", O_DATA_ENABLE, exp_o.de);
      chk("pixel", O_PIXEL, exp_o.pix);
      chk("frame_start", O_FRAME_START, exp_fs);
      chk("hsync_pos", d2_hs, exp_o.hs);
      chk("vsync_pos", d2_vs, exp_o.vs);
      chk("de_pos", d2_de, exp_o.de);
      if (I_ENABLE === 1'b1) begin
        if (rdq.size() == 0) begin
          n_chk++;
          $display("FAIL rdq_underflow at %0t", $time);
        end else begin
          rr = rdq.pop_front();
          chk("read_en", O_READ_ENABLE, rr.re);
          chk("read_col", O_READ_COLUMN, rr.col);
          chk("read_row", O_READ_ROW, rr.row);
          pend_wrap = rr.wrap;
        end
      end else begin
        chk("read_idle", O_READ_ENABLE, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    I_RESET       = 1'b0;
    I_ENABLE      = 1'b0;
    I_FRAME_VALID = 1'b0;
    I_PIXEL       = 8'h0;
    salt          = 8'h0;
    restart_model();
    repeat (3) @(posedge I_CLK);
    #2 I_RESET = 1'b1;
    @(posedge I_CLK); #2;

    // continuous ticks, valid frames, plain col+16*row data
    for (int i = 0; i < 2 * FT; i++) tick(1'b1, 0);
    // frame-valid low at (0,0) then raised mid-frame, then a normal frame
    for (int i = 0; i < FT; i++) tick((m_p == FT - 1) ? 1'b0 : 1'b1, 0);
    for (int i = 0; i < FT; i++) tick(1'b1, 0);
    // one tick in four, scrambled data
    salt = 8'($urandom);
    for (int i = 0; i < 2 * FT; i++) tick(1'b1, 3);
    // random gaps and random frame-valid
    for (int i = 0; i < 4 * FT; i++) tick(($urandom % 4) != 0, $urandom_range(0, 3));

    // reset in the middle of an active line
    for (int i = 0; i < FT && !((m_p % HT) == 2 && (m_p / HT) == 1); i++) tick(1'b1, 0);
    #1 I_RESET = 1'b0;
    I_ENABLE = 1'b0;
    restart_model();
    repeat (2) @(posedge I_CLK);
    #2 I_RESET = 1'b1;
    @(posedge I_CLK); #2;
    for (int i = 0; i < 2 * FT; i++) tick(1'b1, $urandom_range(0, 2));
    repeat (3) @(posedge I_CLK);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
